// File: rtl/mlp_train_sequencer_if.sv
// Streaming interface for mlp_train_sequencer: the inference vector input
// channel and the prediction result output channel, each valid/ready.
// master = the board/test side, slave = the sequencer.
interface mlp_train_sequencer_if #(
    parameter int INPUTS  = 2,
    parameter int OUTPUTS = 1,
    parameter int DW      = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [INPUTS*DW-1:0]  in_values;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUTPUTS*DW-1:0] out_prediction;

    modport master (
        output in_valid, in_values, out_ready,
        input  in_ready, out_valid, out_prediction
    );

    modport slave (
        input  in_valid, in_values, out_ready,
        output in_ready, out_valid, out_prediction
    );
endinterface

// File: rtl/mlp_train_sequencer.sv
// mlp_train_sequencer: replays a small sample table into an MLP core for a
// configured number of epochs with training enabled, then forwards live
// inference vectors and returns captured predictions over valid/ready.
// Optional feature macro MLP_ACC_COUNT_EN adds the acc_correct output, which
// counts samples classified correctly (threshold HALF) in the final epoch.
module mlp_train_sequencer #(
    parameter int INPUTS      = 2,
    parameter int OUTPUTS     = 1,
    parameter int NUM_SAMPLES = 4,
    parameter int DW          = 32,
    parameter int EPOCH_W     = 16,
    parameter int HOLD_W      = 8
`ifdef MLP_ACC_COUNT_EN
    ,
    parameter logic [DW-1:0] HALF = DW'(32'h3F00_0000)
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [EPOCH_W-1:0]             cfg_epochs,
    input  logic [HOLD_W-1:0]              cfg_hold,
    input  logic                           tbl_we,
    input  logic [$clog2(NUM_SAMPLES)-1:0] tbl_addr,
    input  logic [INPUTS*DW-1:0]           tbl_values,
    input  logic [OUTPUTS*DW-1:0]          tbl_expected,
    mlp_train_sequencer_if.slave           io,
    output logic                           mlp_rst,
    output logic                           mlp_training,
    output logic [INPUTS*DW-1:0]           mlp_values,
    output logic [OUTPUTS*DW-1:0]          mlp_expected,
    input  logic [OUTPUTS*DW-1:0]          mlp_prediction,
    output logic                           busy,
    output logic                           done,
    output logic [EPOCH_W-1:0]             epoch
`ifdef MLP_ACC_COUNT_EN
    ,
    output logic [$clog2(NUM_SAMPLES+1)-1:0] acc_correct
`endif
);

    localparam int ADDR_W = $clog2(NUM_SAMPLES);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        TRAIN,
        INFER_IN,
        INFER_WAIT,
        INFER_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [HOLD_W-1:0]      cnt_q, cnt_d;
    logic [EPOCH_W-1:0]     epoch_q, epoch_d;
    logic [EPOCH_W-1:0]     epochs_q, epochs_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [INPUTS*DW-1:0]   infer_vals_q, infer_vals_d;
    logic [OUTPUTS*DW-1:0]  pred_q, pred_d;

    logic [INPUTS*DW-1:0]   tbl_vals_q [NUM_SAMPLES];
    logic [OUTPUTS*DW-1:0]  tbl_exp_q  [NUM_SAMPLES];

    logic [HOLD_W-1:0]      hold_m1;
    logic                   hold_last;
    logic                   idx_last;
    logic [EPOCH_W-1:0]     epoch_inc;

    // A hold of 0 behaves as 1, so the terminal count is max(hold,1)-1.
    assign hold_m1   = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
    assign hold_last = (cnt_q == hold_m1);
    assign idx_last  = (idx_q == ADDR_W'(NUM_SAMPLES - 1));
    assign epoch_inc = (epoch_q == '1) ? epoch_q : epoch_q + EPOCH_W'(1);

    // Sample table: written only while idle or waiting for inference input; never reset.
    always_ff @(posedge clk) begin
        if (tbl_we && !busy) begin
            tbl_vals_q[tbl_addr] <= tbl_values;
            tbl_exp_q[tbl_addr]  <= tbl_expected;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            epoch_q      <= '0;
            epochs_q     <= '0;
            hold_q       <= '0;
            infer_vals_q <= '0;
            pred_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            epoch_q      <= epoch_d;
            epochs_q     <= epochs_d;
            hold_q       <= hold_d;
            infer_vals_q <= infer_vals_d;
            pred_q       <= pred_d;
        end
    end

    // Next-state logic: training replay, then inference handshakes.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        epoch_d      = epoch_q;
        epochs_d     = epochs_q;
        hold_d       = hold_q;
        infer_vals_d = infer_vals_q;
        pred_d       = pred_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    epochs_d = cfg_epochs;
                    hold_d   = cfg_hold;
                    state_d  = INIT;
                end
            end
            INIT: begin
                epoch_d = '0;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = (epochs_q == '0) ? INFER_IN : TRAIN;
            end
            TRAIN: begin
                if (hold_last) begin
                    cnt_d = '0;
                    if (idx_last) begin
                        idx_d   = '0;
                        epoch_d = epoch_inc;
                        if (epoch_inc == epochs_q) begin
                            state_d = INFER_IN;
                        end
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            INFER_IN: begin
                // start has priority over a pending input vector
                if (start) begin
                    epochs_d = cfg_epochs;
                    hold_d   = cfg_hold;
                    state_d  = INIT;
                end else if (io.in_valid) begin
                    infer_vals_d = io.in_values;
                    cnt_d        = '0;
                    state_d      = INFER_WAIT;
                end
            end
            INFER_WAIT: begin
                if (hold_last) begin
                    pred_d  = mlp_prediction;
                    cnt_d   = '0;
                    state_d = INFER_OUT;
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            INFER_OUT: begin
                if (io.out_ready) begin
                    state_d = INFER_IN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mlp_rst        = (state_q == IDLE) || (state_q == INIT);
    assign mlp_training   = (state_q == TRAIN);
    assign busy           = state_q inside {INIT, TRAIN, INFER_WAIT, INFER_OUT};
    assign done           = state_q inside {INFER_IN, INFER_WAIT, INFER_OUT};
    assign epoch          = epoch_q;
    assign io.in_ready    = (state_q == INFER_IN);
    assign io.out_valid   = (state_q == INFER_OUT);
    assign io.out_prediction = pred_q;
    assign mlp_values     = (state_q == TRAIN) ? tbl_vals_q[idx_q] :
                            done               ? infer_vals_q      : '0;
    assign mlp_expected   = (state_q == TRAIN) ? tbl_exp_q[idx_q] : '0;

`ifdef MLP_ACC_COUNT_EN
    localparam int ACC_W = $clog2(NUM_SAMPLES + 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             all_match;

    // Per-output threshold agreement between prediction and target.
    always_comb begin
        all_match = 1'b1;
        for (int unsigned o = 0; o < OUTPUTS; o++) begin
            if ((mlp_prediction[o*DW +: DW] > HALF) != (mlp_expected[o*DW +: DW] > HALF)) begin
                all_match = 1'b0;
            end
        end
    end

    // Count correct samples on each sample's last hold cycle of the final epoch.
    always_comb begin
        acc_d = acc_q;
        if (state_q == INIT) begin
            acc_d = '0;
        end else if ((state_q == TRAIN) && hold_last && (epoch_inc == epochs_q) && all_match) begin
            acc_d = acc_q + ACC_W'(1);
        end
    end

    // Accuracy counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_correct = acc_q;
`endif

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed self-checking bench for mlp_train_sequencer: AND-table training,
// hold=0, zero epochs, inference handshakes with stall, retrain priority,
// async reset mid-training. Define MLP_ACC_COUNT_EN to also check acc_correct.
module tb_mlp_train_sequencer;

    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_epochs = '0;
    logic [7:0]  cfg_hold = '0;
    logic        tbl_we = 1'b0;
    logic [1:0]  tbl_addr = '0;
    logic [63:0] tbl_values = '0;
    logic [31:0] tbl_expected = '0;
    logic        mlp_rst, mlp_training, busy, done;
    logic [63:0] mlp_values;
    logic [31:0] mlp_expected, mlp_prediction;
    logic [15:0] epoch;
    logic [31:0] pred_src = '0;
    logic        stub_echo = 1'b0;
`ifdef MLP_ACC_COUNT_EN
    logic [2:0]  acc_correct;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mlp_train_sequencer_if #(.INPUTS(2), .OUTPUTS(1), .DW(32)) io ();

    mlp_train_sequencer #(
        .INPUTS(2), .OUTPUTS(1), .NUM_SAMPLES(4), .DW(32), .EPOCH_W(16), .HOLD_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_epochs(cfg_epochs), .cfg_hold(cfg_hold),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_values(tbl_values), .tbl_expected(tbl_expected),
        .io(io), .mlp_rst(mlp_rst), .mlp_training(mlp_training), .mlp_values(mlp_values),
        .mlp_expected(mlp_expected), .mlp_prediction(mlp_prediction), .busy(busy), .done(done),
        .epoch(epoch)
`ifdef MLP_ACC_COUNT_EN
        , .acc_correct(acc_correct)
`endif
    );

    // Stub MLP: either echoes the target or returns a bench-chosen word.
    assign mlp_prediction = stub_echo ? mlp_expected : pred_src;

    always #5 clk = ~clk;

    function automatic logic [63:0] sval(input int k);
        logic [31:0] k_bits;
        k_bits = k;
        return {(k_bits[1] ? ONE : 32'h0), (k_bits[0] ? ONE : 32'h0)};
    endfunction

    function automatic logic [31:0] sexp(input int k);
        return (k == 3) ? ONE : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_and_table();
        for (int k = 0; k < 4; k++) begin
            tbl_addr     = 2'(k);
            tbl_values   = sval(k);
            tbl_expected = sexp(k);
            tbl_we       = 1'b1;
            tick();
        end
        tbl_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        n_checks++; if (mlp_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mlp_rst: got %b want 1", mlp_rst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (mlp_training !== 1'b0) begin n_fail++; $display("FAIL reset_training: got %b want 0", mlp_training); end
        n_checks++; if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_handshake: in_ready %b out_valid %b want 0 0", io.in_ready, io.out_valid); end
        n_checks++; if (epoch !== 16'd0 || mlp_values !== 64'd0 || mlp_expected !== 32'd0) begin n_fail++; $display("FAIL reset_data: epoch %h values %h expected %h want zeros", epoch, mlp_values, mlp_expected); end
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_train_and();
        int cnt;
        int guard;
        cfg_epochs = 16'd10;
        cfg_hold   = 8'd3;
        start_pulse();
        n_checks++; if (mlp_rst !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL init_flags: mlp_rst %b busy %b want 1 1", mlp_rst, busy); end
        tick();
        cnt = 0;
        guard = 0;
        while (!done && guard < 400) begin
            if (mlp_training) cnt++;
            tick();
            guard++;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL train_done_timeout: done %b want 1", done); end
        n_checks++; if (cnt != 120) begin n_fail++; $display("FAIL train_cycles: got %0d want 120", cnt); end
        n_checks++; if (epoch !== 16'd10) begin n_fail++; $display("FAIL train_epoch: got %0d want 10", epoch); end
        n_checks++; if (io.in_ready !== 1'b1 || mlp_training !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL train_end_flags: in_ready %b training %b busy %b want 1 0 0", io.in_ready, mlp_training, busy); end
        n_checks++; if (mlp_expected !== 32'd0 || mlp_rst !== 1'b0) begin n_fail++; $display("FAIL infer_expected: expected %h mlp_rst %b want 0 0", mlp_expected, mlp_rst); end
    endtask

    task automatic test_infer_stall();
        int lat;
        pred_src       = 32'h1234_5678;
        io.in_values   = {ONE, ONE};
        io.in_valid    = 1'b1;
        io.out_ready   = 1'b0;
        tick();
        io.in_values = 64'hDEAD_BEEF_0BAD_F00D;
        n_checks++; if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0) begin n_fail++; $display("FAIL accept_flags: in_ready %b out_valid %b want 0 0", io.in_ready, io.out_valid); end
        n_checks++; if (mlp_values !== {ONE, ONE}) begin n_fail++; $display("FAIL accept_values: got %h want %h", mlp_values, {ONE, ONE}); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL wait_flags: busy %b done %b want 1 1", busy, done); end
        lat = 0;
        while (!io.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL out_latency: got %0d want 3", lat); end
        n_checks++; if (io.out_prediction !== 32'h1234_5678) begin n_fail++; $display("FAIL out_capture: got %h want 12345678", io.out_prediction); end
        pred_src = 32'hCAFE_0001;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_checks++; if (io.out_valid !== 1'b1 || io.out_prediction !== 32'h1234_5678 || io.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: out_valid %b pred %h in_ready %b want 1 12345678 0", s, io.out_valid, io.out_prediction, io.in_ready); end
        end
        io.out_ready = 1'b1;
        io.in_values = {ONE, 32'h0};
        tick();
        io.out_ready = 1'b0;
        n_checks++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin n_fail++; $display("FAIL out_handshake: out_valid %b in_ready %b want 0 1", io.out_valid, io.in_ready); end
        tick();
        io.in_valid = 1'b0;
        n_checks++; if (io.in_ready !== 1'b0 || mlp_values !== {ONE, 32'h0}) begin n_fail++; $display("FAIL back_to_back: in_ready %b values %h want 0 %h", io.in_ready, mlp_values, {ONE, 32'h0}); end
        lat = 0;
        while (!io.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++; if (lat != 3 || io.out_prediction !== 32'hCAFE_0001) begin n_fail++; $display("FAIL second_result: latency %0d pred %h want 3 cafe0001", lat, io.out_prediction); end
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
    endtask

    task automatic test_hold_zero();
        cfg_epochs   = 16'd1;
        cfg_hold     = 8'd0;
        start        = 1'b1;
        io.in_valid  = 1'b1;
        io.in_values = {ONE, ONE};
        tick();
        start       = 1'b0;
        io.in_valid = 1'b0;
        n_checks++; if (mlp_rst !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || io.in_ready !== 1'b0) begin n_fail++; $display("FAIL start_wins: mlp_rst %b busy %b done %b in_ready %b want 1 1 0 0", mlp_rst, busy, done, io.in_ready); end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (mlp_training !== 1'b1 || mlp_values !== sval(k) || mlp_expected !== sexp(k) || epoch !== 16'd0) begin n_fail++; $display("FAIL hold0_sample_%0d: training %b values %h expected %h epoch %0d want 1 %h %h 0", k, mlp_training, mlp_values, mlp_expected, epoch, sval(k), sexp(k)); end
            tick();
        end
        n_checks++; if (done !== 1'b1 || mlp_training !== 1'b0 || epoch !== 16'd1) begin n_fail++; $display("FAIL hold0_done: done %b training %b epoch %0d want 1 0 1", done, mlp_training, epoch); end
    endtask

    task automatic test_epochs_zero();
        cfg_epochs = 16'd0;
        cfg_hold   = 8'd2;
        start_pulse();
        n_checks++; if (mlp_training !== 1'b0 || mlp_rst !== 1'b1) begin n_fail++; $display("FAIL zero_init: training %b mlp_rst %b want 0 1", mlp_training, mlp_rst); end
        tick();
        n_checks++; if (io.in_ready !== 1'b1 || done !== 1'b1 || mlp_training !== 1'b0 || epoch !== 16'd0) begin n_fail++; $display("FAIL zero_infer: in_ready %b done %b training %b epoch %0d want 1 1 0 0", io.in_ready, done, mlp_training, epoch); end
    endtask

    task automatic test_reset_mid();
        int guard;
        cfg_epochs = 16'd10;
        cfg_hold   = 8'd3;
        start_pulse();
        guard = 0;
        while (epoch != 16'd5 && guard < 1000) begin
            tick();
            guard++;
        end
        n_checks++; if (epoch !== 16'd5) begin n_fail++; $display("FAIL reach_epoch5: got %0d want 5", epoch); end
        tbl_addr     = 2'd0;
        tbl_values   = '1;
        tbl_expected = '1;
        tbl_we       = 1'b1;
        start        = 1'b1;
        cfg_epochs   = 16'd1;
        tick();
        tbl_we = 1'b0;
        start  = 1'b0;
        tick();
        n_checks++; if (mlp_training !== 1'b1 || epoch !== 16'd5) begin n_fail++; $display("FAIL start_ignored: training %b epoch %0d want 1 5", mlp_training, epoch); end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (mlp_rst !== 1'b1 || busy !== 1'b0 || mlp_training !== 1'b0 || epoch !== 16'd0 || done !== 1'b0) begin n_fail++; $display("FAIL async_reset: mlp_rst %b busy %b training %b epoch %0d done %b want 1 0 0 0 0", mlp_rst, busy, mlp_training, epoch, done); end
        #2 rst = 1'b0;
        tick();
        cfg_epochs = 16'd1;
        cfg_hold   = 8'd1;
        start_pulse();
        tick();
        n_checks++; if (mlp_training !== 1'b1 || epoch !== 16'd0 || mlp_values !== sval(0) || mlp_expected !== sexp(0)) begin n_fail++; $display("FAIL rerun_table: training %b epoch %0d values %h expected %h want 1 0 %h %h", mlp_training, epoch, mlp_values, mlp_expected, sval(0), sexp(0)); end
        guard = 0;
        while (!done && guard < 100) begin
            tick();
            guard++;
        end
        n_checks++; if (done !== 1'b1 || epoch !== 16'd1) begin n_fail++; $display("FAIL rerun_done: done %b epoch %0d want 1 1", done, epoch); end
    endtask

`ifdef MLP_ACC_COUNT_EN
    task automatic test_acc_count();
        int guard;
        stub_echo  = 1'b1;
        cfg_epochs = 16'd2;
        cfg_hold   = 8'd2;
        start_pulse();
        tick();
        n_checks++; if (acc_correct !== 3'd0) begin n_fail++; $display("FAIL acc_cleared: got %0d want 0", acc_correct); end
        guard = 0;
        while (!done && guard < 200) begin tick(); guard++; end
        n_checks++; if (done !== 1'b1 || acc_correct !== 3'd4) begin n_fail++; $display("FAIL acc_echo: done %b acc %0d want 1 4", done, acc_correct); end
        stub_echo = 1'b0;
        pred_src  = 32'h0;
        start_pulse();
        guard = 0;
        while (!done && guard < 200) begin tick(); guard++; end
        tick();
        n_checks++; if (done !== 1'b1 || acc_correct !== 3'd3) begin n_fail++; $display("FAIL acc_zero: done %b acc %0d want 1 3", done, acc_correct); end
    endtask
`endif

    initial begin
        io.in_valid  = 1'b0;
        io.in_values = '0;
        io.out_ready = 1'b0;
        test_reset();
        load_and_table();
        test_train_and();
        test_infer_stall();
        test_hold_zero();
        test_epochs_zero();
        test_reset_mid();
`ifdef MLP_ACC_COUNT_EN
        test_acc_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
